l1d_cache_nway: RTL



---
 rtl/l1d_pkg.sv | 30 +++
 rtl/l1d_sram.sv | 24 ++
 rtl/l1d_cache_nway.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/l1d_pkg.sv
// l1d_pkg: shared codes, FSM state type and byte-lane helpers for the L1D cache.
//   Exports: cop codes (COP_*), size codes (SZ_*), state_e, lane_be, lane_shift, lane_load.
package l1d_pkg;

    localparam logic [2:0] COP_RD   = 3'd0;
    localparam logic [2:0] COP_WR   = 3'd1;
    localparam logic [2:0] COP_RDNC = 3'd2;
    localparam logic [2:0] COP_WRNC = 3'd3;

    localparam logic [2:0] SZ_B = 3'd1;
    localparam logic [2:0] SZ_H = 3'd2;

    typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_MISS, S_REFILL, S_WRITE, S_NC} state_e;

    function automatic logic [3:0] lane_be(input logic [2:0] size, input logic [1:0] a);
        return (size == SZ_B ? 4'b0001 : size == SZ_H ? 4'b0011 : 4'b1111) << a;
    endfunction

    function automatic logic [31:0] lane_shift(input logic [31:0] d, input logic [1:0] a);
        return d << {a, 3'b000};
    endfunction

    // Brings the addressed lane down to bit 0 and clears everything above the access size.
    function automatic logic [31:0] lane_load(input logic [31:0] d, input logic [1:0] a, input logic [2:0] size);
        logic [31:0] s;
        s = d >> {a, 3'b000};
        return size == SZ_B ? {24'b0, s[7:0]} : size == SZ_H ? {16'b0, s[15:0]} : s;
    endfunction

endpackage

// File: rtl/l1d_sram.sv
// l1d_sram: single-port synchronous-read RAM with per-lane write enables.
//   clk: clock; addr: row; we: one enable per WIDTH/LANES-bit lane; wdata: write row; rdata: row read last cycle.
module l1d_sram #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 64,
    parameter int LANES = 1
) (
    input  logic                     clk,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [LANES-1:0]         we,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata
);
    localparam int LW = WIDTH / LANES;

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++)
            if (we[i]) mem[addr][i*LW +: LW] <= wdata[i*LW +: LW];
        rdata <= mem[addr];
    end

endmodule

// File: rtl/l1d_cache_nway.sv
// l1d_cache_nway: blocking write-through, no-write-allocate N-way L1 data cache between LSU and MAU.
//   core_req_*: LSU request (held until core_req_ack); core_ack_data: load data with the ack.
//   inv_req/inv_done: invalidate-all pulse and its completion pulse.
//   mau_req_*: MAU request (held until mau_req_ack); mau_ack_data: refill line or NC word.
module l1d_cache_nway
    import l1d_pkg::*;
#(
    parameter int WAYS       = 4,
    parameter int SETS       = 64,
    parameter int LINE_BYTES = 16,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    core_req_val,
    input  logic [ADDR_W-1:0]       core_req_addr,
    input  logic [2:0]              core_req_cop,
    input  logic [DATA_W-1:0]       core_req_wdata,
    input  logic [2:0]              core_req_size,
    output logic                    core_req_ack,
    output logic [DATA_W-1:0]       core_ack_data,
    input  logic                    inv_req,
    output logic                    inv_done,
    output logic                    mau_req_val,
    output logic                    mau_req_nc,
    output logic                    mau_req_we,
    output logic [ADDR_W-1:0]       mau_req_addr,
    output logic [DATA_W-1:0]       mau_req_wdata,
    output logic [3:0]              mau_req_be,
    input  logic                    mau_req_ack,
    input  logic [LINE_BYTES*8-1:0] mau_ack_data
);
    localparam int OFF_W  = $clog2(LINE_BYTES);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
    localparam int WAY_W  = WAYS > 1 ? $clog2(WAYS) : 1;
    localparam int LINE_W = LINE_BYTES * 8;

    state_e                    state;
    logic [ADDR_W-1:0]         addr_q;
    logic [2:0]                cop_q, size_q;
    logic [DATA_W-1:0]         wdata_q;
    logic [LINE_W-1:0]         line_q;
    logic [WAYS-1:0]           valid [SETS];
    logic [WAY_W-1:0]          rr [SETS];

    logic [TAG_W-1:0]          tag_rd [WAYS];
    logic [LINE_W-1:0]         data_rd [WAYS];
    logic [WAYS-1:0]           tag_we, hit_vec;
    logic [LINE_BYTES-1:0]     data_we [WAYS];
    logic [LINE_W-1:0]         hit_line, ram_wdata, sel_line;
    logic                      hit, has_inv;
    logic [WAY_W-1:0]          inv_way, victim;
    logic [31:0]               rd_data;

    wire [TAG_W-1:0]      tag_q      = addr_q[ADDR_W-1 -: TAG_W];
    wire [IDX_W-1:0]      idx_q      = addr_q[OFF_W +: IDX_W];
    // Arrays are read with the incoming index in IDLE so tags/data are ready in LOOKUP.
    wire [IDX_W-1:0]      ram_idx    = state == S_IDLE ? core_req_addr[OFF_W +: IDX_W] : idx_q;
    wire [OFF_W-1:0]      word_sel   = addr_q[OFF_W-1:0] >> 2;
    wire [3:0]            be         = lane_be(size_q, addr_q[1:0]);
    wire [31:0]           lane_wdata = lane_shift(wdata_q, addr_q[1:0]);
    wire [LINE_BYTES-1:0] be_line    = LINE_BYTES'(be) << (4 * int'(word_sel));
    wire [WAY_W-1:0]      rr_next    = WAY_W'((int'(rr[idx_q]) + 1) % WAYS);

    always_comb begin
        hit_vec  = '0;
        hit_line = '0;
        has_inv  = 1'b0;
        inv_way  = '0;
        // Descending scan so the lowest-numbered invalid way wins.
        for (int w = WAYS - 1; w >= 0; w--) begin
            hit_vec[w] = valid[idx_q][w] && tag_rd[w] == tag_q;
            hit_line   = hit_line | (hit_vec[w] ? data_rd[w] : '0);
            if (!valid[idx_q][w]) begin
                has_inv = 1'b1;
                inv_way = WAY_W'(w);
            end
        end
    end

    assign hit       = |hit_vec;
    assign victim    = has_inv ? inv_way : rr[idx_q];
    assign ram_wdata = state == S_REFILL ? line_q : {(LINE_BYTES/4){lane_wdata}};
    assign sel_line  = state == S_REFILL ? line_q : hit_line;
    assign rd_data   = lane_load(state == S_NC ? mau_ack_data[31:0] : sel_line[32*int'(word_sel) +: 32],
                                 addr_q[1:0], size_q);

    for (genvar g = 0; g < WAYS; g++) begin : g_way
        assign tag_we[g]  = state == S_REFILL && victim == WAY_W'(g);
        assign data_we[g] = tag_we[g] ? '1 :
                            (state == S_LOOKUP && cop_q == COP_WR && hit_vec[g]) ? be_line : '0;
        l1d_sram #(.WIDTH(TAG_W), .DEPTH(SETS), .LANES(1)) u_tag (
            .clk(clk), .addr(ram_idx), .we(tag_we[g]), .wdata(tag_q), .rdata(tag_rd[g]));
        l1d_sram #(.WIDTH(LINE_W), .DEPTH(SETS), .LANES(LINE_BYTES)) u_data (
            .clk(clk), .addr(ram_idx), .we(data_we[g]), .wdata(ram_wdata), .rdata(data_rd[g]));
    end

    assign core_req_ack  = (state == S_LOOKUP && cop_q == COP_RD && hit) || state == S_REFILL ||
                           ((state == S_WRITE || state == S_NC) && mau_req_ack);
    assign core_ack_data = core_req_ack && (cop_q == COP_RD || cop_q == COP_RDNC) ? rd_data : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            inv_done    <= 1'b0;
            mau_req_val <= 1'b0;
            mau_req_nc  <= 1'b0;
            mau_req_we  <= 1'b0;
            for (int s = 0; s < SETS; s++) begin
                valid[s] <= '0;
                rr[s]    <= '0;
            end
        end else begin
            inv_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (inv_req) begin
                        inv_done <= 1'b1;
                        for (int s = 0; s < SETS; s++) begin
                            valid[s] <= '0;
                            rr[s]    <= '0;
                        end
                    end else if (core_req_val) begin
                        addr_q  <= core_req_addr;
                        cop_q   <= core_req_cop;
                        size_q  <= core_req_size;
                        wdata_q <= core_req_wdata;
                        if (core_req_cop == COP_RD || core_req_cop == COP_WR) begin
                            state <= S_LOOKUP;
                        end else begin
                            state         <= S_NC;
                            mau_req_val   <= 1'b1;
                            mau_req_nc    <= 1'b1;
                            mau_req_we    <= core_req_cop == COP_WRNC;
                            mau_req_addr  <= {core_req_addr[ADDR_W-1:2], 2'b00};
                            mau_req_be    <= lane_be(core_req_size, core_req_addr[1:0]);
                            mau_req_wdata <= lane_shift(core_req_wdata, core_req_addr[1:0]);
                        end
                    end
                end
                S_LOOKUP: begin
                    state         <= cop_q == COP_WR ? S_WRITE : hit ? S_IDLE : S_MISS;
                    mau_req_val   <= cop_q == COP_WR || !hit;
                    mau_req_nc    <= 1'b0;
                    mau_req_we    <= cop_q == COP_WR;
                    mau_req_addr  <= cop_q == COP_WR ? {addr_q[ADDR_W-1:2], 2'b00}
                                                     : {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    mau_req_be    <= cop_q == COP_WR ? be : 4'hF;
                    mau_req_wdata <= cop_q == COP_WR ? lane_wdata : '0;
                end
                S_MISS: begin
                    if (mau_req_ack) begin
                        line_q      <= mau_ack_data;
                        mau_req_val <= 1'b0;
                        state       <= S_REFILL;
                    end
                end
                S_REFILL: begin
                    valid[idx_q][victim] <= 1'b1;
                    if (!has_inv) rr[idx_q] <= rr_next;
                    state <= S_IDLE;
                end
                default: begin
                    if (mau_req_ack) begin
                        mau_req_val <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
            endcase
        end
    end

    a_val_held: assert property (@(posedge clk) disable iff (!rst_n) state != S_IDLE |-> core_req_val);
    a_req_legal: assert property (@(posedge clk) disable iff (!rst_n)
        state == S_IDLE && core_req_val && !inv_req |->
        core_req_cop <= COP_WRNC &&
        (core_req_size == SZ_B || (core_req_size == SZ_H ? !core_req_addr[0] : core_req_addr[1:0] == 2'b00)));

endmodule
